// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : Constants and types shared by the UART blocks. Holds the
//            transmit-arbiter FSM encoding and the 8N1 payload width.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Payload bits carried by one 8N1 frame
  localparam int UART_DATA_W = 8;

  // Transmit arbiter controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } tx_arb_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. Searches ptr+1, ptr+2, ...
//            modulo N_REQ and returns the first valid requester as a one-hot
//            vector and as an index.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         onehot_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);

  localparam int IDX_W = $clog2(N_REQ);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // The search covers every channel once, so any valid input yields a pick
  assign any_o = |valid_i;

  // Walk the channels starting just after the pointer; first valid one wins
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand     = (int'(ptr_i) + off) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && valid_i[cand_idx]) begin
        found              = 1'b1;
        onehot_o[cand_idx] = 1'b1;
        idx_o              = cand_idx;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one 8N1 UART transmitter between N_REQ byte-stream
//            requesters. Round-robin arbitration only at frame boundaries;
//            a granted channel keeps the transmitter until it sends a byte
//            flagged last, goes idle too long mid-frame, or the transmitter
//            fails to go busy.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096,
  parameter int BUSY_WD = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             grant,
  output logic [UART_DATA_W-1:0]       tx_data,
  output logic                         tx_data_rdy,
  input  logic                         tx_transm_rdy,
  output logic                         frame_abort,
  output logic                         tx_error
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int WD_W  = $clog2(BUSY_WD + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(BUSY_WD - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);

  tx_arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_data_rdy_q, tx_data_rdy_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
  logic                   frame_abort_q, frame_abort_d;
  logic                   tx_error_q, tx_error_d;

  logic [N_REQ-1:0]       pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  logic                   sel_valid;
  logic [UART_DATA_W-1:0] sel_data;
  logic                   sel_last;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .valid_i  (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // The grant index always equals rr_ptr, so it selects the owner's inputs
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_ptr_q == IDX_W'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[UART_DATA_W*i +: UART_DATA_W];
        sel_last  = req_last[i];
      end
    end
  end

  // Next-state and registered-output logic; strobes default low each cycle
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    tx_data_d     = tx_data_q;
    tx_data_rdy_d = 1'b0;
    last_d        = last_q;
    idle_cnt_d    = idle_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    frame_abort_d = 1'b0;
    tx_error_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Transmitter may still be finishing a byte from before a reset
        if (tx_transm_rdy && pick_any) begin
          grant_d    = pick_oh;
          rr_ptr_d   = pick_idx;
          idle_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (sel_valid) begin
          tx_data_d     = sel_data;
          tx_data_rdy_d = 1'b1;
          last_d        = sel_last;
          wd_cnt_d      = '0;
          state_d       = BUSY;
        end else if (idle_cnt_q == CNT_LAST) begin
          frame_abort_d = 1'b1;
          grant_d       = '0;
          state_d       = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (!tx_transm_rdy) begin
          state_d = DONE;
        end else if (wd_cnt_q == WD_LAST) begin
          tx_error_d = 1'b1;
          grant_d    = '0;
          state_d    = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (tx_transm_rdy) begin
          if (last_q) begin
            grant_d = '0;
            state_d = IDLE;
          end else begin
            idle_cnt_d = '0;
            state_d    = GRANT;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= PTR_RST;
      tx_data_q     <= '0;
      tx_data_rdy_q <= 1'b0;
      last_q        <= 1'b0;
      idle_cnt_q    <= '0;
      wd_cnt_q      <= '0;
      frame_abort_q <= 1'b0;
      tx_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      tx_data_q     <= tx_data_d;
      tx_data_rdy_q <= tx_data_rdy_d;
      last_q        <= last_d;
      idle_cnt_q    <= idle_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      frame_abort_q <= frame_abort_d;
      tx_error_q    <= tx_error_d;
    end
  end

  assign req_ready   = (state_q == GRANT) ? grant_q : '0;
  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_data_rdy = tx_data_rdy_q;
  assign frame_abort = frame_abort_q;
  assign tx_error    = tx_error_q;

endmodule : uart_tx_arbiter
`default_nettype wire
